alu_result_stage: RTL and testbench

Registered result stage directly downstream of `alu_functions`. It takes that block's parallel result buses and raw flags, selects one result per accepted operation by opcode, and holds it in a 2-entry output queue with valid/ready handshake. It also maintains the architectural NZCV flag register. It decouples the combinational ALU from the writeback consumer so that consumer stalls do not ripple into the ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/alu_result_fifo.sv | 100 ++++++++++
 rtl/alu_result_stage.sv | 141 ++++++++++++++
 tb/tb_alu_result_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
//
// Contents:
//   alu_op_e    - 3-bit result-select opcodes (ALU_OP_ADD .. ALU_OP_CHK)
//   ALU_DATA_W  - default result/operand width
//   FLG_N/Z/C/V - bit positions inside the architectural {N,Z,C,V} register
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_OP_ADD = 3'd0,
        ALU_OP_SUB = 3'd1,
        ALU_OP_AND = 3'd2,
        ALU_OP_OR  = 3'd3,
        ALU_OP_XOR = 3'd4,
        ALU_OP_SFL = 3'd5,
        ALU_OP_SFR = 3'd6,
        ALU_OP_CHK = 3'd7
    } alu_op_e;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_result_stage_if.sv
// Downstream result stream of alu_result_stage (valid/ready handshake).
//
// Signals:
//   out_valid - head entry valid           (stage -> consumer)
//   out_ready - consumer takes head        (consumer -> stage)
//   out_data  - head result, DATA_W bits   (stage -> consumer)
//   out_op    - opcode of head entry       (stage -> consumer)
// Modports: master = result stage, slave = writeback consumer.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_op;

    modport master (
        output out_valid,
        output out_data,
        output out_op,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_op,
        output out_ready
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Two-entry synchronous FIFO of {op, data} with registered full/empty flags.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   push, push_op/data    - write request and tail entry (ignored when full or flushing)
//   pop                   - remove head (ignored when empty)
//   flush                 - drop all entries at the next edge; no write that cycle
//   head_op, head_data    - current head entry
//   full, empty           - registered occupancy flags
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [2:0]        push_op,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [2:0]        head_op,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    logic [2:0]        op_q   [2];
    logic [DATA_W-1:0] data_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_en;
    logic              pop_en;

    assign push_en = push & ~full_q & ~flush;
    assign pop_en  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
        end else begin
            if (push_en) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push_en && !pop_en) begin
                empty_d = 1'b0;
                full_d  = (wr_ptr_d == rd_ptr_q);
            end else if (pop_en && !push_en) begin
                full_d  = 1'b0;
                empty_d = (rd_ptr_d == wr_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q[0]   <= '0;
            op_q[1]   <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else if (push_en) begin
            op_q[wr_ptr_q]   <= push_op;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_op   = op_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind alu_functions: selects one result bus per
// accepted operation, queues it (2 deep) towards writeback, and maintains the
// architectural NZCV flag register.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - upstream handshake; in_ready = !full & !flush
//   op, set_flags       - result select and flag-update enable
//   flush               - synchronous queue clear (flags/counter untouched)
//   *_out               - alu_functions result buses
//   cf, nf, zf, vf      - alu_functions raw flags
//   out                 - downstream stream (alu_result_stage_if.master)
//   flags               - architectural {N,Z,C,V}
//   acc_cnt             - accepted-operation counter
//
// Build option: define ALU_RESULT_CNT_EN to implement acc_cnt; otherwise it
// is tied to zero and no counter state exists.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic              set_flags,
    input  logic              flush,
    input  logic [DATA_W-1:0] add_out,
    input  logic [DATA_W-1:0] sub_out,
    input  logic [DATA_W-1:0] and_out,
    input  logic [DATA_W-1:0] or_out,
    input  logic [DATA_W-1:0] xor_out,
    input  logic [DATA_W-1:0] sfl_out,
    input  logic [DATA_W-1:0] sfr_out,
    input  logic [DATA_W-1:0] chk_out,
    input  logic              cf,
    input  logic              nf,
    input  logic              zf,
    input  logic              vf,
    alu_result_stage_if.master out,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  acc_cnt
);

    logic [DATA_W-1:0] sel_data;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2:0]        head_op;
    logic [DATA_W-1:0] head_data;
    logic [3:0]        flags_q, flags_d;

    // in_ready comes only from registered occupancy and flush.
    assign in_ready = ~fifo_full & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = ~fifo_empty & out.out_ready;

    always_comb begin
        sel_data = '0;
        unique case (op)
            ALU_OP_ADD: sel_data = add_out;
            ALU_OP_SUB: sel_data = sub_out;
            ALU_OP_AND: sel_data = and_out;
            ALU_OP_OR:  sel_data = or_out;
            ALU_OP_XOR: sel_data = xor_out;
            ALU_OP_SFL: sel_data = sfl_out;
            ALU_OP_SFR: sel_data = sfr_out;
            ALU_OP_CHK: sel_data = chk_out;
            default:    sel_data = '0;
        endcase
    end

    alu_result_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_op   (op),
        .push_data (sel_data),
        .pop       (pop),
        .flush     (flush),
        .head_op   (head_op),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out.out_valid = ~fifo_empty;
    assign out.out_data  = head_data;
    assign out.out_op    = head_op;

    // Arithmetic ops take the ALU's flags verbatim; logic/shift/check ops
    // only derive N and Z from the selected result and keep C and V.
    always_comb begin
        flags_d = flags_q;
        if (push && set_flags) begin
            if (op == ALU_OP_ADD || op == ALU_OP_SUB) begin
                flags_d[FLG_N] = nf;
                flags_d[FLG_Z] = zf;
                flags_d[FLG_C] = cf;
                flags_d[FLG_V] = vf;
            end else begin
                flags_d[FLG_N] = sel_data[DATA_W-1];
                flags_d[FLG_Z] = (sel_data == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

`ifdef ALU_RESULT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Free-running wrap; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign acc_cnt = cnt_q;
`else
    assign acc_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = '0;
    logic          set_flags = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] add_out = '0, sub_out = '0, and_out = '0, or_out = '0;
    logic [DW-1:0] xor_out = '0, sfl_out = '0, sfr_out = '0, chk_out = '0;
    logic          cf = 1'b0, nf = 1'b0, zf = 1'b0, vf = 1'b0;
    logic [3:0]    flags;
    logic [CW-1:0] acc_cnt;

    alu_result_stage_if #(.DATA_W(DW)) s_if ();

    alu_result_stage #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .set_flags (set_flags),
        .flush     (flush),
        .add_out   (add_out),
        .sub_out   (sub_out),
        .and_out   (and_out),
        .or_out    (or_out),
        .xor_out   (xor_out),
        .sfl_out   (sfl_out),
        .sfr_out   (sfr_out),
        .chk_out   (chk_out),
        .cf        (cf),
        .nf        (nf),
        .zf        (zf),
        .vf        (vf),
        .out       (s_if.master),
        .flags     (flags),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    entry_t        sb_q[$];
    logic [3:0]    exp_flags = 4'b0000;
    logic [CW-1:0] exp_cnt = '0;
    logic [DW-1:0] cur_val = '0;
    logic          last_acc = 1'b0;
    logic [3:0]    saved_flags;
    int            n_pass = 0;
    int            n_chk = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one op; the chosen bus carries v, every other bus is noise.
    task automatic drive(input logic [2:0] o, input logic [DW-1:0] v, input logic sf,
                         input logic [3:0] nzcv);
        in_valid  = 1'b1;
        op        = o;
        set_flags = sf;
        {nf, zf, cf, vf} = nzcv;
        add_out = $urandom; sub_out = $urandom; and_out = $urandom; or_out = $urandom;
        xor_out = $urandom; sfl_out = $urandom; sfr_out = $urandom; chk_out = $urandom;
        case (o)
            3'd0: add_out = v;
            3'd1: sub_out = v;
            3'd2: and_out = v;
            3'd3: or_out  = v;
            3'd4: xor_out = v;
            3'd5: sfl_out = v;
            3'd6: sfr_out = v;
            default: chk_out = v;
        endcase
        cur_val = v;
    endtask

    // Called at a falling edge with inputs set: check outputs against the
    // scoreboard, advance the model across the next rising edge.
    task automatic cycle();
        logic exp_valid, exp_ready, acc, pop;
        #1;
        exp_valid = (sb_q.size() != 0);
        exp_ready = (sb_q.size() < 2) && !flush;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", s_if.out_valid, exp_valid);
        check("flags", flags, exp_flags);
        check("acc_cnt", acc_cnt, exp_cnt);
        if (exp_valid) begin
            check("out_data", s_if.out_data, sb_q[0].data);
            check("out_op", s_if.out_op, sb_q[0].op);
        end
        pop = exp_valid && s_if.out_ready;
        acc = in_valid && exp_ready;
        if (pop) void'(sb_q.pop_front());
        if (flush) sb_q.delete();
        if (acc) begin
            sb_q.push_back('{op: op, data: cur_val});
`ifdef ALU_RESULT_CNT_EN
            exp_cnt = exp_cnt + 1'b1;
`endif
            if (set_flags) begin
                if (op < 3'd2) exp_flags = {nf, zf, cf, vf};
                else exp_flags = {cur_val[DW-1], cur_val == '0, exp_flags[1:0]};
            end
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] o, input logic [DW-1:0] v, input logic sf,
                        input logic [3:0] nzcv);
        drive(o, v, sf, nzcv);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_acc) break;
        end
        check("send_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        s_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", s_if.out_valid, 1'b0);
        check("rst_out_data", s_if.out_data, 32'h0);
        check("rst_out_op", s_if.out_op, 3'd0);
        check("rst_flags", flags, 4'b0000);
        check("rst_acc_cnt", acc_cnt, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Single add, one-cycle latency.
        s_if.out_ready = 1'b1;
        send(3'd0, 32'h0000_000E, 1'b1, 4'b0000);
        #1;
        check("add_valid", s_if.out_valid, 1'b1);
        check("add_data", s_if.out_data, 32'h0000_000E);
        check("add_op", s_if.out_op, 3'd0);
        check("add_flags", flags, 4'b0000);

        // Sub takes raw flags, then AND derives N/Z and keeps C/V.
        send(3'd1, 32'hFFFF_FFFA, 1'b1, 4'b1010);
        #1 check("sub_flags", flags, 4'b1010);
        send(3'd2, 32'h0000_0000, 1'b1, 4'b0000);
        #1 check("and_flags", flags, 4'b0110);
        cycle();
        cycle();

        // Back-pressure: third op waits until the consumer drains.
        s_if.out_ready = 1'b0;
        send(3'd3, 32'h1111_1111, 1'b0, 4'b0000);
        send(3'd4, 32'h2222_2222, 1'b0, 4'b0000);
        drive(3'd5, 32'h3333_3333, 1'b0, 4'b0000);
        repeat (3) cycle();
        check("full_in_ready", in_ready, 1'b0);
        s_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_acc) break;
        end
        check("third_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
        repeat (2) cycle();

        // Occupancy 1 with simultaneous push and pop.
        s_if.out_ready = 1'b0;
        send(3'd6, 32'hABCD_0001, 1'b0, 4'b0000);
        drive(3'd4, 32'h0000_0005, 1'b0, 4'b0000);
        s_if.out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        s_if.out_ready = 1'b0;
        #1;
        check("pp_valid", s_if.out_valid, 1'b1);
        check("pp_head", s_if.out_data, 32'h0000_0005);
        check("pp_op", s_if.out_op, 3'd4);
        cycle();

        // Fill, then flush with a pending push and a pop.
        send(3'd7, 32'h8000_0000, 1'b1, 4'b0000);
        check("fill_full", in_ready, 1'b0);
        saved_flags = exp_flags;
        flush = 1'b1;
        drive(3'd0, 32'h0000_0099, 1'b1, 4'b1111);
        s_if.out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_valid", s_if.out_valid, 1'b0);
        check("flush_flags", flags, saved_flags);
        cycle();

        // Asynchronous reset mid-stream.
        s_if.out_ready = 1'b0;
        send(3'd3, 32'h8000_0001, 1'b1, 4'b0000);
        send(3'd0, 32'h0000_0042, 1'b1, 4'b1111);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", s_if.out_valid, 1'b0);
        check("arst_flags", flags, 4'b0000);
        check("arst_data", s_if.out_data, 32'h0);
        sb_q.delete();
        exp_flags = 4'b0000;
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // 17 accepts: a 4-bit counter wraps to 1.
        s_if.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(3'(i), 32'(i + 1), 1'b0, 4'b0000);
        end
        #1;
`ifdef ALU_RESULT_CNT_EN
        check("cnt_wrap", acc_cnt, 4'd1);
`else
        check("cnt_tied", acc_cnt, 4'd0);
`endif
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global bound so a stuck DUT can never hang the run.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
